// File: rtl/fixed_point_pkg.sv
// Shared Q/N sign-magnitude fixed-point definitions: default widths, word struct
// and the helper that normalises -0 to +0.
package fixed_point_pkg;

    localparam int unsigned FxpQ = 15;
    localparam int unsigned FxpN = 32;

    typedef struct packed {
        logic            sign;
        logic [FxpN-2:0] mag;
    } sign_mag_t;

    function automatic sign_mag_t to_sign_mag(input logic sign, input logic [FxpN-2:0] mag);
        sign_mag_t r;
        r.sign = sign & (|mag);
        r.mag  = mag;
        return r;
    endfunction

endpackage

// File: rtl/fxp_mag_addsub.sv
// Combinational magnitude add/subtract for sign-magnitude operands; sign_sel=1 means
// the result takes the sign of operand B, otherwise the sign of operand A.
module fxp_mag_addsub #(
    parameter int unsigned N = 32
) (
    input  logic [N-2:0] ma,
    input  logic [N-2:0] mb,
    input  logic         same_sign,
    input  logic         a_ge_b,
    output logic [N-2:0] mag,
    output logic         sign_sel,
    output logic         ovf
);

    logic [N-1:0] sum;

    always_comb begin
        sum      = {1'b0, ma} + {1'b0, mb};
        mag      = '0;
        sign_sel = 1'b0;
        ovf      = 1'b0;
        if (same_sign) begin
            if (sum[N-1]) begin
                mag = '1;
                ovf = 1'b1;
            end else begin
                mag = sum[N-2:0];
            end
        end else if (a_ge_b) begin
            mag = ma - mb;
        end else begin
            mag      = mb - ma;
            sign_sel = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_point_adder_pipe.sv
// Two-stage sign-magnitude fixed-point adder/subtractor with saturation and
// valid/ready flow control; the pipeline holds at most two results.
module fixed_point_adder_pipe
    import fixed_point_pkg::*;
#(
    parameter int unsigned Q = FxpQ,
    parameter int unsigned N = FxpN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    // The result struct is sized from the package, so the word width must match it.
    if (N != FxpN) begin : gen_bad_n
        $error("fixed_point_adder_pipe: N must equal fixed_point_pkg::FxpN");
    end
    if (Q >= N - 1) begin : gen_bad_q
        $error("fixed_point_adder_pipe: Q must be smaller than the magnitude width");
    end

    logic         s1_valid_q, s1_valid_d;
    logic         sa_q, sa_d;
    logic         sb_q, sb_d;
    logic [N-2:0] ma_q, ma_d;
    logic [N-2:0] mb_q, mb_d;
    logic         same_sign_q, same_sign_d;
    logic         a_ge_b_q, a_ge_b_d;
    logic         out_valid_q, out_valid_d;
    sign_mag_t    c_q, c_d;
    logic         ovf_q, ovf_d;

    logic         adv1, adv2;
    logic         sb_eff;
    logic [N-2:0] s2_mag;
    logic         s2_sign_sel;
    logic         s2_ovf;

    fxp_mag_addsub #(
        .N (N)
    ) u_mag_addsub (
        .ma        (ma_q),
        .mb        (mb_q),
        .same_sign (same_sign_q),
        .a_ge_b    (a_ge_b_q),
        .mag       (s2_mag),
        .sign_sel  (s2_sign_sel),
        .ovf       (s2_ovf)
    );

    always_comb begin
        adv2   = !out_valid_q || out_ready;
        adv1   = !s1_valid_q || adv2;
        sb_eff = b[N-1] ^ sub;

        s1_valid_d  = s1_valid_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        same_sign_d = same_sign_q;
        a_ge_b_d    = a_ge_b_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        ovf_d       = ovf_q;

        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                sa_d        = a[N-1];
                sb_d        = sb_eff;
                ma_d        = a[N-2:0];
                mb_d        = b[N-2:0];
                same_sign_d = (a[N-1] == sb_eff);
                a_ge_b_d    = (a[N-2:0] >= b[N-2:0]);
            end
        end

        // Bubbles advance out_valid only; the last result stays on c/ovf.
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d   = to_sign_mag(s2_sign_sel ? sb_q : sa_q, s2_mag);
                ovf_d = s2_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            same_sign_q <= 1'b0;
            a_ge_b_q    <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            same_sign_q <= same_sign_d;
            a_ge_b_q    <= a_ge_b_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_point_adder_pipe.sv
// Randomised and directed bench for fixed_point_adder_pipe against a signed-integer
// reference model with an in-order expected-result queue.
module tb_fixed_point_adder_pipe;

    localparam int unsigned N = 32;
    localparam int unsigned NDir = 8;

    localparam logic [N-1:0] DirA [NDir] = '{
        32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000,
        32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [N-1:0] DirB [NDir] = '{
        32'h0000_8000, 32'h8000_8000, 32'h0001_0000, 32'h8000_8000,
        32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 32'h0000_0000};
    localparam logic DirS [NDir] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [N-1:0] DirC [NDir] = '{
        32'h0001_8000, 32'h0000_8000, 32'h8000_8000, 32'h0000_0000,
        32'h0000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic DirO [NDir] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] c;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [N:0] exp_q [$];
    logic [N:0] cur_exp = '0;
    logic       hold_pending = 1'b0;
    logic [N:0] held = '0;

    always #5 clk = ~clk;

    fixed_point_adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Signed arithmetic on the decoded values, then clamp and re-encode.
    function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic ms);
        longint va, vb, r, m;
        logic   sgn, o;
        va = longint'(ma[N-2:0]);
        if (ma[N-1]) va = -va;
        vb = longint'(mb[N-2:0]);
        if (mb[N-1] ^ ms) vb = -vb;
        r   = va + vb;
        sgn = (r < 0);
        m   = sgn ? -r : r;
        o   = 1'b0;
        if (m > 64'h7FFF_FFFF) begin
            m = 64'h7FFF_FFFF;
            o = 1'b1;
        end
        if (m == 0) sgn = 1'b0;
        return {sgn, m[N-2:0], o};
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-2:0] m;
        logic         s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
            0:       m = '0;
            1:       m = '1;
            2:       m = 31'($urandom_range(0, 255));
            3:       m = 31'h7FFF_FF00 + 31'($urandom_range(0, 255));
            default: m = 31'($urandom());
        endcase
        return {s, m};
    endfunction

    // One clock: sample handshakes at negedge, return 1 ns after the rising edge.
    task automatic step(output bit acc);
        logic [N:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(cur_exp);
        if (out_valid && hold_pending) check_eq("hold_stable", 64'({c, ovf}), 64'(held));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("c", 64'(c), 64'(e[N:1]));
                check_eq("ovf", 64'(ovf), 64'(e[0]));
            end
        end
        hold_pending = out_valid && !out_ready;
        held         = {c, ovf};
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic ts,
                        input logic [N:0] te);
        bit acc;
        acc      = 1'b0;
        a        = ta;
        b        = tb_v;
        sub      = ts;
        cur_exp  = te;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) step(acc);
        check_eq("send_accepted", 64'(acc), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(acc);
        check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        bit          acc;
        int          idx;
        logic [N-1:0] bp_a [5];
        logic [N-1:0] bp_b [5];
        logic         bp_s [5];

        // Reset state
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_c", 64'(c), 64'(0));
        check_eq("rst_ovf", 64'(ovf), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: capture edge, then result one edge later
        out_ready = 1'b1;
        a         = DirA[0];
        b         = DirB[0];
        sub       = DirS[0];
        cur_exp   = {DirC[0], DirO[0]};
        in_valid  = 1'b1;
        step(acc);
        in_valid = 1'b0;
        check_eq("lat_accepted", 64'(acc), 64'(1));
        check_eq("lat_not_yet", 64'(out_valid), 64'(0));
        step(acc);
        check_eq("lat_valid", 64'(out_valid), 64'(1));
        check_eq("lat_c", 64'(c), 64'(DirC[0]));
        drain();

        // Directed vectors streamed back to back
        for (int i = 0; i < NDir; i++) send(DirA[i], DirB[i], DirS[i], {DirC[i], DirO[i]});
        drain();

        // Backpressure: 6 stalled cycles, only 2 entries fit
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = rand_op();
            bp_b[i] = rand_op();
            bp_s[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        idx       = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            a        = bp_a[idx];
            b        = bp_b[idx];
            sub      = bp_s[idx];
            cur_exp  = model(bp_a[idx], bp_b[idx], bp_s[idx]);
            in_valid = 1'b1;
            step(acc);
            if (acc) idx++;
        end
        check_eq("bp_accepted", 64'(idx), 64'(2));
        check_eq("bp_in_ready", 64'(in_ready), 64'(0));
        check_eq("bp_out_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 30 && idx < 5; i++) begin
            a        = bp_a[idx];
            b        = bp_b[idx];
            sub      = bp_s[idx];
            cur_exp  = model(bp_a[idx], bp_b[idx], bp_s[idx]);
            in_valid = 1'b1;
            step(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check_eq("bp_all_sent", 64'(idx), 64'(5));
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h0000_4000, 32'h0000_4000, 1'b0, {32'h0000_8000, 1'b0});
        send(32'h0003_0000, 32'h0001_0000, 1'b1, {32'h0002_0000, 1'b0});
        check_eq("full_in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("mid_rst_c", 64'(c), 64'(0));
        check_eq("mid_rst_ovf", 64'(ovf), 64'(0));
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("post_rst_out_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send(32'h8001_0000, 32'h0000_8000, 1'b1, {32'h8001_8000, 1'b0});
        drain();

        // Random traffic with random stalls
        acc = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a        = rand_op();
                b        = rand_op();
                sub      = 1'($urandom_range(0, 1));
                cur_exp  = model(a, b, sub);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
